uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_tx_bit_sel.sv | 26 ++
 rtl/uart_tx_framer.sv | 144 ++++++++++++++
 tb/tb_uart_tx_framer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// States, parity encodings, line idle level and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int MAX_DW = 9;

  localparam logic LINE_IDLE = 1'b1;

  function automatic logic par_calc(
    input logic [MAX_DW-1:0] d,
    input int                mode
  );
    logic x;
    x = ^d;
    return (mode == PAR_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_tx_bit_sel.sv
// Line level select for the UART transmitter.
// Picks start/data/parity/stop/idle level from the FSM state.
module uart_tx_bit_sel
  import uart_pkg::*;
(
  input  tx_state_e state_i,
  input  logic      data_bit_i,
  input  logic      par_bit_i,
  input  logic      brk_i,
  output logic      line_o
);

  always_comb begin
    line_o = LINE_IDLE;
    unique case (state_i)
      IDLE:   line_o = brk_i ? ~LINE_IDLE : LINE_IDLE;
      PEND:   line_o = LINE_IDLE;
      START:  line_o = ~LINE_IDLE;
      DATA:   line_o = data_bit_i;
      PARITY: line_o = par_bit_i;
      STOP:   line_o = LINE_IDLE;
      default: line_o = LINE_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, LSB-first data, optional parity, stop.
// Define UART_TX_BREAK_EN to add the tx_break line-break input.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = PAR_NONE,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  baud_tick,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
`ifdef UART_TX_BREAK_EN
  input  logic                  tx_break,
`endif
  output logic                  tx_ready,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  frame_done
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  par_q, par_d;
  logic                  brk_q, brk_d;
  logic                  ser_q, ser_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  brk_in;
  logic                  accept;

`ifdef UART_TX_BREAK_EN
  assign brk_in = tx_break;
`else
  assign brk_in = 1'b0;
`endif

  assign tx_ready = (state_q == IDLE) && !brk_q;
  assign accept   = tx_valid && tx_ready;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    brk_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PEND;
          sh_d    = tx_data;
          cnt_d   = '0;
          par_d   = par_calc(MAX_DW'(tx_data), PARITY_MODE);
        end else begin
          // Break only engages between frames
          brk_d = brk_in;
        end
      end
      PEND: begin
        if (baud_tick) state_d = START;
      end
      START: begin
        if (baud_tick) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (cnt_q == LAST_DATA) begin
            state_d = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            cnt_d   = '0;
          end else begin
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_d = STOP;
          cnt_d   = '0;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (cnt_q == LAST_STOP) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Line level is chosen from next-state so it lands with the state change
  uart_tx_bit_sel u_bit_sel (
    .state_i    (state_d),
    .data_bit_i (sh_d[0]),
    .par_bit_i  (par_d),
    .brk_i      (brk_d),
    .line_o     (ser_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      brk_q   <= 1'b0;
      ser_q   <= LINE_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      brk_q   <= brk_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_serial  = ser_q;
  assign tx_busy    = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: four parameterisations, line scoreboard.
// Break checks run when UART_TX_BREAK_EN is defined.
module tb_uart_tx_framer;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       baud_tick = 1'b0;
  logic [3:0] valid     = '0;
  logic [7:0] data0     = '0;
  logic [7:0] data1     = '0;
  logic [7:0] data2     = '0;
  logic [8:0] data3     = '0;
  logic [3:0] ready, ser, busy, done;
`ifdef UART_TX_BREAK_EN
  logic       brk0      = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int tcnt   = 0;
  int cyc    = 0;
  int glitches = 0;

  bit exp_q [4][$];
  int rem       [4] = '{0, 0, 0, 0};
  bit act       [4] = '{0, 0, 0, 0};
  bit mon_en    [4] = '{1, 1, 1, 1};
  int done_cnt  [4] = '{0, 0, 0, 0};
  int done_cyc  [4] = '{0, 0, 0, 0};
  int end_cyc   [4] = '{0, 0, 0, 0};
  int start_cyc [4] = '{0, 0, 0, 0};
  int LEN [4] = '{10, 12, 11, 12};
  int WID [4] = '{8, 8, 8, 9};
  int PAR [4] = '{0, 1, 2, 1};
  int STP [4] = '{1, 2, 1, 1};
  logic [3:0] prev_ser  = '0;
  logic [3:0] prev_busy = '0;
  logic       t_prev;

  always #5 clk = ~clk;

  uart_tx_framer u_d0 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .tx_valid(valid[0]), .tx_data(data0),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk0),
`endif
    .tx_ready(ready[0]), .tx_serial(ser[0]),
    .tx_busy(busy[0]), .frame_done(done[0])
  );

  uart_tx_framer #(.PARITY_MODE(1), .STOP_BITS(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .tx_valid(valid[1]), .tx_data(data1),
`ifdef UART_TX_BREAK_EN
    .tx_break(1'b0),
`endif
    .tx_ready(ready[1]), .tx_serial(ser[1]),
    .tx_busy(busy[1]), .frame_done(done[1])
  );

  uart_tx_framer #(.PARITY_MODE(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .tx_valid(valid[2]), .tx_data(data2),
`ifdef UART_TX_BREAK_EN
    .tx_break(1'b0),
`endif
    .tx_ready(ready[2]), .tx_serial(ser[2]),
    .tx_busy(busy[2]), .frame_done(done[2])
  );

  uart_tx_framer #(.DATA_WIDTH(9), .PARITY_MODE(1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .tx_valid(valid[3]), .tx_data(data3),
`ifdef UART_TX_BREAK_EN
    .tx_break(1'b0),
`endif
    .tx_ready(ready[3]), .tx_serial(ser[3]),
    .tx_busy(busy[3]), .frame_done(done[3])
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int i, input logic [8:0] d);
    bit p;
    p = 1'b0;
    exp_q[i].push_back(1'b0);
    for (int j = 0; j < WID[i]; j++) begin
      exp_q[i].push_back(d[j]);
      p ^= d[j];
    end
    if (PAR[i] != 0) exp_q[i].push_back((PAR[i] == 2) ? ~p : p);
    for (int j = 0; j < STP[i]; j++) exp_q[i].push_back(1'b1);
  endtask

  task automatic drive(input int i, input logic [8:0] d);
    case (i)
      0: data0 = d[7:0];
      1: data1 = d[7:0];
      2: data2 = d[7:0];
      default: data3 = d;
    endcase
    valid[i] = 1'b1;
  endtask

  task automatic wait_done(input int i, input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt[i] < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("done_wait%0d", i), 32'(done_cnt[i] >= target), 32'd1);
  endtask

  // Tick generator and line monitor; bits sampled just before each tick edge
  always @(negedge clk) begin
    t_prev = baud_tick;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (ser[i] !== prev_ser[i] && busy[i] && prev_busy[i] && !t_prev)
        glitches++;
      if (done[i] === 1'b1) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
        check($sformatf("done_align%0d", i), 32'(cyc - end_cyc[i]), 32'd1);
      end
    end
    prev_ser  = ser;
    prev_busy = busy;
    baud_tick = (tcnt == 15);
    tcnt = (tcnt + 1) % 16;
    if (baud_tick) begin
      for (int i = 0; i < 4; i++) begin
        if (mon_en[i]) begin
          if (!act[i] && ser[i] === 1'b0) begin
            check($sformatf("frame_expected%0d", i),
                  32'(exp_q[i].size() != 0), 32'd1);
            if (exp_q[i].size() != 0) begin
              act[i] = 1'b1;
              rem[i] = LEN[i];
              start_cyc[i] = cyc;
            end
          end
          if (act[i]) begin
            check($sformatf("line%0d", i), 32'(ser[i]),
                  32'(exp_q[i].pop_front()));
            rem[i]--;
            if (rem[i] == 0) begin
              act[i] = 1'b0;
              end_cyc[i] = cyc;
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int e1;
    int dc;
    int exp_done0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_ser%0d", i), 32'(ser[i]), 32'd1);
      check($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      check($sformatf("rst_done%0d", i), 32'(done[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("idle_ready%0d", i), 32'(ready[i]), 32'd1);
    repeat (40) @(negedge clk);

    // One frame on every configuration at once
    drive(0, 9'h0A5); push_frame(0, 9'h0A5);
    drive(1, 9'h007); push_frame(1, 9'h007);
    drive(2, 9'h007); push_frame(2, 9'h007);
    drive(3, 9'h1FF); push_frame(3, 9'h1FF);
    @(negedge clk);
    valid = '0;
    check("busy_after_xfer", 32'(busy), 32'hF);
    check("ready_after_xfer", 32'(ready), 32'h0);
    data1 = 8'hFF;
    data3 = 9'h000;
    drive(0, 9'h0FF);
    repeat (3) @(negedge clk);
    valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) wait_done(i, 1, 400);
    check("stop2_len", 32'(done_cyc[1] - done_cyc[2]), 32'd16);
    repeat (20) @(negedge clk);

    // Back-to-back frames with tx_valid held high
    drive(0, 9'h011); push_frame(0, 9'h011);
    @(negedge clk);
    check("b2b_busy1", 32'(busy[0]), 32'd1);
    data0 = 8'h22; push_frame(0, 9'h022);
    k = 0;
    while (done[0] !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("b2b_done_seen", 32'(done[0]), 32'd1);
    check("b2b_ready", 32'(ready[0]), 32'd1);
    e1 = end_cyc[0];
    @(negedge clk);
    check("b2b_accept", 32'(busy[0]), 32'd1);
    valid[0] = 1'b0;
    data0 = 8'h5A;
    wait_done(0, 3, 400);
    check("b2b_gap", 32'(start_cyc[0] - e1), 32'd32);
    repeat (20) @(negedge clk);

    // Reset during data bit 3
    drive(0, 9'h03C); push_frame(0, 9'h03C);
    @(negedge clk);
    valid[0] = 1'b0;
    k = 0;
    while (ser[0] !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rst_start_seen", 32'(ser[0]), 32'd0);
    repeat (72) @(negedge clk);
    dc = done_cnt[0];
    mon_en[0] = 1'b0;
    rst_n = 1'b0;
    exp_q[0].delete();
    act[0] = 1'b0;
    @(negedge clk);
    check("abort_ser", 32'(ser[0]), 32'd1);
    check("abort_busy", 32'(busy[0]), 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(done_cnt[0]), 32'(dc));
    check("abort_ready", 32'(ready[0]), 32'd1);
    mon_en[0] = 1'b1;
    drive(0, 9'h0C3); push_frame(0, 9'h0C3);
    @(negedge clk);
    valid[0] = 1'b0;
    wait_done(0, 4, 400);
    exp_done0 = 4;

`ifdef UART_TX_BREAK_EN
    repeat (20) @(negedge clk);
    mon_en[0] = 1'b0;
    @(negedge clk);
    brk0 = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      check("brk_line", 32'(ser[0]), 32'd0);
      check("brk_ready", 32'(ready[0]), 32'd0);
    end
    brk0 = 1'b0;
    @(negedge clk);
    check("brk_release_line", 32'(ser[0]), 32'd1);
    check("brk_release_ready", 32'(ready[0]), 32'd1);
    mon_en[0] = 1'b1;
    repeat (5) @(negedge clk);
    drive(0, 9'h096); push_frame(0, 9'h096);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (30) @(negedge clk);
    brk0 = 1'b1;
    repeat (50) @(negedge clk);
    brk0 = 1'b0;
    wait_done(0, 5, 400);
    exp_done0 = 5;
`endif

    repeat (40) @(negedge clk);
    check("glitches", 32'(glitches), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("q_empty%0d", i), 32'(exp_q[i].size()), 32'd0);
      check($sformatf("idle_end%0d", i), 32'(ser[i]), 32'd1);
    end
    check("done_total0", 32'(done_cnt[0]), 32'(exp_done0));
    for (int i = 1; i < 4; i++)
      check($sformatf("done_total%0d", i), 32'(done_cnt[i]), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
